multicycle_controller: RTL and testbench
========================================

# multicycle_controller

Finite-state sequencer for a multicycle RV32I core, driving a shared-ALU / unified-memory datapath. It replaces the single-cycle combinational controller: each instruction is split into 3–5 clocked steps, so one ALU and one memory port are reused across the fetch, address, execute and writeback phases. It sits beside the multicycle datapath and reads its instruction-register fields and ALU `zero` flag.

## Interface
Parameters: none.

Ports:
- `clock` input 1: system clock; all state updates on its rising edge.
- `reset` input 1: synchronous, active-high.
- `opcode` input 7: instruction-register bits [6:0].
- `funct3` input 3: instruction-register bits [14:12].
- `funct7b5` input 1: instruction-register bit 30.
- `zero` input 1: ALU result equals zero.
- `PC_write` output 1: PC register enable.
- `address_select` output 1: memory address source. 0 = PC, 1 = ALU-out register.
- `IR_write` output 1: instruction/old-PC register enable.
- `mem_write` output 1: memory write strobe.
- `reg_write` output 1: register-file write enable.
- `result_select` output 2: result mux. 00 = ALU-out register, 01 = data register, 10 = ALU result.
- `ALU_select_A` output 2: ALU A mux. 00 = PC, 01 = old PC, 10 = rs1.
- `ALU_select_B` output 2: ALU B mux. 00 = rs2, 01 = immediate, 10 = constant 4.
- `immediate_select` output 2: immediate format. 00 = I, 01 = S, 10 = B, 11 = J.
- `ALU_control` output 3: ALU operation. 000 = add, 001 = sub, 010 = and, 011 = or, 101 = slt.
- `instruction_done` output 1: high during the final step of each instruction.
- `state` output 4: current state, for debug.
- `illegal` output 1: sticky illegal-opcode flag. Present only with `ILLEGAL_HALT_EN`.

## Operation
- The controller is a Moore FSM. All outputs are combinational from `state`, except three:
  - `ALU_control` also depends on `funct3`, `funct7b5` and `opcode[5]`.
  - `immediate_select` depends on `opcode` only.
  - `PC_write` = PC_update | (branch & `zero`).
- State encodings and per-state outputs (unlisted outputs are 0; ALU op 00 = add, 01 = sub, 10 = funct-decoded):
  - 0 FETCH: address_select=0, IR_write=1, A=00, B=10, op 00, result_select=10, PC_update=1.
  - 1 DECODE: A=01, B=01, op 00 (branch target into ALU-out).
  - 2 MEMADR: A=10, B=01, op 00.
  - 3 MEMREAD: result_select=00, address_select=1.
  - 4 MEMWB: result_select=01, reg_write=1.
  - 5 MEMWRITE: result_select=00, address_select=1, mem_write=1.
  - 6 EXECUTER: A=10, B=00, op 10.
  - 7 ALUWB: result_select=00, reg_write=1.
  - 8 EXECUTEI: A=10, B=01, op 10.
  - 9 JAL: A=01, B=10, op 00, result_select=00, PC_update=1.
  - 10 BEQ: A=10, B=00, op 01, result_select=00, branch=1.
- Transitions:
  - FETCH → DECODE.
  - DECODE dispatches on opcode:
    - 0000011 (lw) or 0100011 (sw) → MEMADR.
    - 0110011 → EXECUTER.
    - 0010011 → EXECUTEI.
    - 1101111 → JAL.
    - 1100011 → BEQ.
    - Any other opcode → FETCH.
  - MEMADR → MEMREAD if opcode = lw, otherwise MEMWRITE.
  - MEMREAD → MEMWB → FETCH.
  - MEMWRITE → FETCH.
  - EXECUTER, EXECUTEI and JAL → ALUWB → FETCH.
  - BEQ → FETCH.
- Funct decode (op 10), keyed on `funct3`:
  - 000: sub if `opcode[5]` & `funct7b5`, else add.
  - 010: slt.
  - 110: or.
  - 111: and.
  - Other values: add.
- `immediate_select` by opcode: sw → 01; beq → 10; jal → 11; all others → 00.
- `instruction_done` is high in MEMWB, MEMWRITE, ALUWB and BEQ, and in DECODE when DECODE returns to FETCH.
- Opcode and funct inputs are consumed only in DECODE and later states. They must stay stable from the cycle after FETCH until `instruction_done`.

## Timing
- Reset is synchronous. With `reset` high at a rising edge, `state` becomes FETCH, overriding any transition. This holds mid-instruction: there are no partial writes after that edge.
- Outputs during reset and immediately after equal the FETCH row (PC_write=1, IR_write=1, all others per the FETCH row).
- Cycles per instruction, counted from FETCH inclusive:
  - lw: 5.
  - sw, R-type, I-type, jal: 4.
  - beq: 3.
  - Unknown opcode: 2.
- Branch: `PC_write` in BEQ follows `zero` combinationally within the same cycle. The PC loads the DECODE-computed target at the BEQ→FETCH edge.
- mem_write and reg_write are each asserted for exactly one cycle per instruction.

## Configuration
- `ILLEGAL_HALT_EN` defined:
  - Adds state 11 HALT. DECODE on an unlisted opcode → HALT.
  - HALT holds until reset. All enables are 0; `illegal`=1 and `instruction_done`=0.
  - `illegal` clears only on reset.
- Not defined:
  - Unlisted opcodes are treated as NOPs (DECODE → FETCH).
  - There is no `illegal` port and no state 11.

## Test plan
- Reset held 2 cycles, then released: state=0, PC_write=1, IR_write=1, ALU_select_B=10, all other enables 0.
- lw (opcode 0000011): states 0,1,2,3,4,0. reg_write=1 only in state 4, with result_select=01. address_select=1 in state 3.
- R-type sub (0110011, funct3 000, funct7b5 1): ALU_control=001 in state 6. With funct7b5=0, ALU_control=000. reg_write=1 in state 7 only.
- beq with zero=1, then zero=0: states 0,1,10,0 in both cases. PC_write=1 in state 10 only when zero=1. instruction_done=1 in state 10.
- sw then jal back-to-back: sw gives mem_write=1 for one cycle in state 5, immediate_select=01. jal gives states 9,7 with PC_write=1 in 9, result_select=00 and immediate_select=11.
- Unknown opcode 1111111: without the macro, states 0,1,0. With `ILLEGAL_HALT_EN`, state 11 and `illegal`=1 persist for 20 cycles, then clear on reset.
- Reset asserted while in state 3 (MEMREAD): the next state is 0, and reg_write is never asserted.

Source files
------------

// File: rtl/multicycle_controller.sv
// multicycle_controller: Moore FSM sequencing a shared-ALU, unified-memory RV32I datapath.
// Define ILLEGAL_HALT_EN to trap unlisted opcodes in a sticky HALT state with an illegal flag.
module multicycle_controller (
  input  logic       clock,
  input  logic       reset,
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       zero,
  output logic       PC_write,
  output logic       address_select,
  output logic       IR_write,
  output logic       mem_write,
  output logic       reg_write,
  output logic [1:0] result_select,
  output logic [1:0] ALU_select_A,
  output logic [1:0] ALU_select_B,
  output logic [1:0] immediate_select,
  output logic [2:0] ALU_control,
  output logic       instruction_done,
`ifdef ILLEGAL_HALT_EN
  output logic       illegal,
`endif
  output logic [3:0] state
);
  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECUTER = 4'd6,
    ALUWB    = 4'd7,
    EXECUTEI = 4'd8,
    JAL      = 4'd9,
`ifdef ILLEGAL_HALT_EN
    BEQ      = 4'd10,
    HALT     = 4'd11
`else
    BEQ      = 4'd10
`endif
  } state_t;
  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
`ifdef ILLEGAL_HALT_EN
  localparam state_t BAD_OP = HALT;
`else
  localparam state_t BAD_OP = FETCH;
`endif
  state_t state_q, state_d;
  logic pc_update, branch;
  logic [1:0] alu_op;
  logic [2:0] funct_op;
  always_ff @(posedge clock)
    if (reset) state_q <= FETCH;
    else state_q <= state_d;
  always_comb begin
    state_d = FETCH;
    case (state_q)
      FETCH:    state_d = DECODE;
      DECODE:   state_d = (opcode == OP_LW || opcode == OP_SW) ? MEMADR :
                          opcode == OP_R   ? EXECUTER :
                          opcode == OP_I   ? EXECUTEI :
                          opcode == OP_JAL ? JAL :
                          opcode == OP_BEQ ? BEQ : BAD_OP;
      MEMADR:   state_d = opcode == OP_LW ? MEMREAD : MEMWRITE;
      MEMREAD:  state_d = MEMWB;
      EXECUTER, EXECUTEI, JAL: state_d = ALUWB;
`ifdef ILLEGAL_HALT_EN
      HALT:     state_d = HALT;
`endif
      default:  state_d = FETCH;
    endcase
  end
  always_comb begin
    address_select = 1'b0;
    IR_write       = 1'b0;
    mem_write      = 1'b0;
    reg_write      = 1'b0;
    result_select  = 2'b00;
    ALU_select_A   = 2'b00;
    ALU_select_B   = 2'b00;
    alu_op         = 2'b00;
    pc_update      = 1'b0;
    branch         = 1'b0;
    case (state_q)
      FETCH:    begin IR_write = 1'b1; ALU_select_B = 2'b10; result_select = 2'b10; pc_update = 1'b1; end
      DECODE:   begin ALU_select_A = 2'b01; ALU_select_B = 2'b01; end
      MEMADR:   begin ALU_select_A = 2'b10; ALU_select_B = 2'b01; end
      MEMREAD:  address_select = 1'b1;
      MEMWB:    begin result_select = 2'b01; reg_write = 1'b1; end
      MEMWRITE: begin address_select = 1'b1; mem_write = 1'b1; end
      EXECUTER: begin ALU_select_A = 2'b10; alu_op = 2'b10; end
      ALUWB:    reg_write = 1'b1;
      EXECUTEI: begin ALU_select_A = 2'b10; ALU_select_B = 2'b01; alu_op = 2'b10; end
      JAL:      begin ALU_select_A = 2'b01; ALU_select_B = 2'b10; pc_update = 1'b1; end
      BEQ:      begin ALU_select_A = 2'b10; alu_op = 2'b01; branch = 1'b1; end
      default:  ;
    endcase
  end
  // Subtract only for R-type (opcode[5]) with funct7b5; addi ignores the bit.
  assign funct_op = funct3 == 3'b000 ? ((opcode[5] & funct7b5) ? 3'b001 : 3'b000) :
                    funct3 == 3'b010 ? 3'b101 :
                    funct3 == 3'b110 ? 3'b011 :
                    funct3 == 3'b111 ? 3'b010 : 3'b000;
  assign ALU_control = alu_op == 2'b00 ? 3'b000 : alu_op == 2'b01 ? 3'b001 : funct_op;
  assign immediate_select = opcode == OP_SW ? 2'b01 : opcode == OP_BEQ ? 2'b10 : opcode == OP_JAL ? 2'b11 : 2'b00;
  assign PC_write = pc_update | (branch & zero);
  assign instruction_done = state_q inside {MEMWB, MEMWRITE, ALUWB, BEQ} || (state_q == DECODE && state_d == FETCH);
  assign state = state_q;
`ifdef ILLEGAL_HALT_EN
  assign illegal = state_q == HALT;
`endif
endmodule

// File: tb/tb_multicycle_controller.sv
// tb_multicycle_controller: directed walk through every instruction class with hand-computed expectations.
module tb_multicycle_controller;
  logic clock = 1'b0, reset = 1'b1, funct7b5 = 1'b0, zero = 1'b0;
  logic [6:0] opcode = 7'b0000011;
  logic [2:0] funct3 = 3'b000;
  logic PC_write, address_select, IR_write, mem_write, reg_write, instruction_done;
  logic [1:0] result_select, ALU_select_A, ALU_select_B, immediate_select;
  logic [2:0] ALU_control;
  logic [3:0] state;
`ifdef ILLEGAL_HALT_EN
  logic illegal;
`endif
  int n_cmp = 0, n_bad = 0;
  multicycle_controller dut (
    .clock(clock), .reset(reset), .opcode(opcode), .funct3(funct3), .funct7b5(funct7b5), .zero(zero),
    .PC_write(PC_write), .address_select(address_select), .IR_write(IR_write), .mem_write(mem_write),
    .reg_write(reg_write), .result_select(result_select), .ALU_select_A(ALU_select_A),
    .ALU_select_B(ALU_select_B), .immediate_select(immediate_select), .ALU_control(ALU_control),
    .instruction_done(instruction_done),
`ifdef ILLEGAL_HALT_EN
    .illegal(illegal),
`endif
    .state(state)
  );
  always #5 clock = ~clock;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic nxt;
    @(negedge clock);
  endtask
  task automatic st(input string tag, input logic [3:0] exp);
    nxt;
    check(tag, state, exp);
  endtask
  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end
  initial begin
    repeat (2) nxt;
    check("rst_state", state, 0);
    check("rst_pcw", PC_write, 1);
    check("rst_irw", IR_write, 1);
    check("rst_selb", ALU_select_B, 2'b10);
    check("rst_en", {address_select, mem_write, reg_write, instruction_done}, 0);
    reset = 1'b0;
    check("rel_state", state, 0);
    check("rel_res", result_select, 2'b10);
    st("lw_s1", 1);
    check("lw_pcw1", PC_write, 0);
    st("lw_s2", 2);
    check("lw_sel", {ALU_select_A, ALU_select_B}, 4'b1001);
    st("lw_s3", 3);
    check("lw_adr3", address_select, 1);
    check("lw_rw3", reg_write, 0);
    st("lw_s4", 4);
    check("lw_rw4", reg_write, 1);
    check("lw_res4", result_select, 2'b01);
    check("lw_done4", instruction_done, 1);
    st("lw_s0", 0);
    check("lw_rw0", reg_write, 0);
    opcode = 7'b0110011; funct3 = 3'b000; funct7b5 = 1'b1;
    st("sub_s1", 1);
    st("sub_s6", 6);
    check("sub_alu", ALU_control, 3'b001);
    check("sub_rw6", reg_write, 0);
    st("sub_s7", 7);
    check("sub_rw7", reg_write, 1);
    check("sub_res7", result_select, 2'b00);
    st("sub_s0", 0);
    funct7b5 = 1'b0;
    st("add_s1", 1);
    st("add_s6", 6);
    check("add_alu", ALU_control, 3'b000);
    st("add_s7", 7);
    st("add_s0", 0);
    funct3 = 3'b110;
    st("or_s1", 1);
    st("or_s6", 6);
    check("or_alu", ALU_control, 3'b011);
    st("or_s7", 7);
    st("or_s0", 0);
    opcode = 7'b0010011; funct3 = 3'b000; funct7b5 = 1'b1;
    st("addi_s1", 1);
    st("addi_s8", 8);
    check("addi_alu", ALU_control, 3'b000);
    check("addi_selb", ALU_select_B, 2'b01);
    funct3 = 3'b010;
    #1 check("slti_alu", ALU_control, 3'b101);
    funct3 = 3'b111;
    #1 check("andi_alu", ALU_control, 3'b010);
    st("addi_s7", 7);
    st("addi_s0", 0);
    opcode = 7'b1100011; zero = 1'b1;
    st("beq1_s1", 1);
    st("beq1_s10", 10);
    check("beq1_pcw", PC_write, 1);
    check("beq1_done", instruction_done, 1);
    check("beq1_alu", ALU_control, 3'b001);
    check("beq1_imm", immediate_select, 2'b10);
    st("beq1_s0", 0);
    zero = 1'b0;
    st("beq0_s1", 1);
    check("beq0_pcw1", PC_write, 0);
    st("beq0_s10", 10);
    check("beq0_pcw", PC_write, 0);
    check("beq0_done", instruction_done, 1);
    zero = 1'b1;
    #1 check("beq_zcomb", PC_write, 1);
    zero = 1'b0;
    st("beq0_s0", 0);
    opcode = 7'b0100011;
    st("sw_s1", 1);
    st("sw_s2", 2);
    check("sw_imm", immediate_select, 2'b01);
    st("sw_s5", 5);
    check("sw_mw5", mem_write, 1);
    check("sw_adr5", address_select, 1);
    check("sw_done", instruction_done, 1);
    st("sw_s0", 0);
    check("sw_mw0", mem_write, 0);
    opcode = 7'b1101111;
    st("jal_s1", 1);
    st("jal_s9", 9);
    check("jal_pcw", PC_write, 1);
    check("jal_res", result_select, 2'b00);
    check("jal_imm", immediate_select, 2'b11);
    check("jal_sel", {ALU_select_A, ALU_select_B}, 4'b0110);
    st("jal_s7", 7);
    check("jal_rw7", reg_write, 1);
    st("jal_s0", 0);
    opcode = 7'b1111111;
    st("unk_s1", 1);
`ifdef ILLEGAL_HALT_EN
    check("unk_done1", instruction_done, 0);
    for (int i = 0; i < 20; i++) begin
      st("halt_state", 11);
      check("halt_ill", illegal, 1);
      check("halt_en", {PC_write, IR_write, mem_write, reg_write, instruction_done}, 0);
    end
    reset = 1'b1;
    st("halt_rst", 0);
    check("halt_clr", illegal, 0);
    reset = 1'b0;
`else
    check("unk_done1", instruction_done, 1);
    st("unk_s0", 0);
`endif
    opcode = 7'b0000011;
    st("rlw_s1", 1);
    st("rlw_s2", 2);
    st("rlw_s3", 3);
    reset = 1'b1;
    st("rlw_rst", 0);
    check("rlw_rw", reg_write, 0);
    reset = 1'b0;
    opcode = 7'b1100011;
    st("rlw_n1", 1);
    check("rlw_rw1", reg_write, 0);
    st("rlw_n10", 10);
    check("rlw_rw10", reg_write, 0);
    st("rlw_n0", 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
